seg7_scan: RTL
==============

# seg7_scan

Time-multiplexed driver for an 8-digit common-anode seven-segment display.
- Holds a 32-bit display word (eight hex nibbles) and drives it to the `select8` nibble selector.
- Steps the digit index `sel` at a programmable rate and reads back the chosen nibble.
- Decodes that nibble and produces registered active-low anode, segment and decimal-point outputs.
- New data loads atomically at frame boundaries; adds anti-ghosting gaps and optional leading-zero blanking.

## Interface
- `DIV`, 100000: clock cycles per digit slot; legal range 4..2^24.
- `GAP`, 4: blanking cycles at the start of each slot; legal range 1..`DIV`-2.
- `clk` in 1: the block's single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `datain` in 32: new display word, sampled when `load`=1.
- `load` in 1: single-cycle request to display `datain`.
- `en` in 1: scan enable.
- `blank_zero` in 1: enables leading-zero blanking.
- `dp_mask` in 8: bit i=1 lights the decimal point of digit i; used live, not latched.
- `data_q` out 32: active display word; connects to `select8.datain`.
- `sel` out 3: current digit index; connects to `select8.sel`.
- `nibble` in 4: connects from `select8.y`.
- `an` out 8: digit anodes, active-low, one-hot when lit.
- `seg` out 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp` out 1: decimal point, active-low.
- `pending` out 1: a loaded word is waiting for the next frame boundary.
- `frame_done` out 1: one-cycle pulse at each frame boundary.

## Operation
- **Reset values:** `sel`=0, prescaler=0, `an`=8'hFF, `seg`=7'h7F, `dp`=1, `data_q`=0, staging=0, `pending`=0, `frame_done`=0.
- **Prescaler `pcnt`:** counts 0..`DIV`-1 while `en`=1. `tick` asserts when `pcnt`=`DIV`-1; on `tick`, `pcnt` returns to 0 and `sel` increments, wrapping 7→0.
- **Frame boundary:** a `tick` with `sel`=7.
  - `frame_done`=1 in the following cycle.
  - If `pending`=1, `data_q` takes the staging value.
- **Load handshake:**
  - `load`=1 writes `datain` into staging and sets `pending`.
  - A further `load` while `pending`=1 overwrites staging; last write wins.
  - `pending` clears at the boundary transfer.
  - If `load` and a boundary coincide, the transfer uses the old staging value, the new word is captured, and `pending` stays 1 (new word applies at the next boundary).
- **Digit blanking:** digit `sel` is blanked (`an`=FF, `seg`=7F, `dp`=1) when any of these holds:
  - `pcnt` < `GAP`;
  - `en`=0;
  - `blank_zero`=1, `sel`≠0, and nibbles `sel`..7 of `data_q` are all zero.
- **Lit digit:** when not blanked, `an` = ~(1<<`sel`), `seg` = decode(`nibble`), `dp` = ~`dp_mask[sel]`. Decode covers full hex 0–F.
- **`en`=0:** `pcnt` and `sel` hold, outputs are blanked, and loads are still accepted. `data_q` does not update without a `tick`. Scanning resumes from the held state when `en` returns to 1.
- **Reset mid-frame:** all state returns to the reset values immediately; any staged word is discarded.

## Timing
- `sel` and `data_q` are registered; `nibble` returns combinationally through `select8` in the same cycle.
- `an`, `seg` and `dp` are registered, so each is one cycle behind the `sel`/`pcnt` state that produced it.
- Slot length is exactly `DIV` cycles; frame length is 8×`DIV` cycles.
- Visible on-time per slot is `DIV`-`GAP` cycles.
- Latency from `load` to display depends on load timing:
  - Best case: the load lands just before the boundary `tick`; `data_q` changes one cycle after it.
  - Worst case: the load coincides with the boundary; about 8×`DIV`+1 cycles.
- `frame_done` goes high in the same cycle that `data_q` updates.

## Structure
- Package `seg7_pkg` holds:
  - `NDIGITS`=8;
  - the 16-entry active-low pattern constants `SEG_0`..`SEG_F` (`SEG_0`=7'h40, `SEG_1`=7'h79, `SEG_8`=7'h00, `SEG_F`=7'h0E);
  - `SEG_OFF`=7'h7F and `AN_OFF`=8'hFF.
- Sub-module `seg7_decode` is combinational: 4-bit nibble → 7-bit active-low pattern, built from the package constants.
- `seg7_scan` contains the prescaler, scan counter, staging register, leading-zero logic and output registers.
- `select8` is instantiated beside this block at the display top level, not inside it.

## Test plan
All scenarios use `DIV`=8, `GAP`=2.
- **Reset / walk:** apply reset; load 32'h76543210 with `en`=1. After the next boundary, check per slot:
  - `an` walks FE, FD, …, 7F;
  - `seg` follows 40, 79, … per digit;
  - `an`=FF for the first 2 cycles of each slot.
- **Boundary load:** load 32'hDEADBEEF mid-frame. Check:
  - `pending`=1 until the boundary;
  - `data_q` changes and `frame_done` pulses at the boundary;
  - no torn frame is ever displayed.
- **Coincident / back-to-back loads:**
  - Load A, then load B on the boundary cycle: A shows, `pending` stays 1, and B shows one frame later.
  - Two loads within one frame: only the second is displayed.
- **Leading-zero blanking:** `blank_zero`=1 with `data_q`=32'h00000120. Check:
  - digits 7..3 show `an`=FF;
  - digits 2, 1, 0 light and show 1, 2, 0.
  - With `data_q`=0, only digit 0 lights, showing `SEG_0`.
- **Enable / reset mid-frame / dp:**
  - Drop `en` at slot 3: outputs blank, `sel` holds at 3, and the slot resumes on re-enable.
  - Pulse `rst_n` low mid-slot: outputs are FF/7F/1 immediately and `data_q`=0.
  - `dp_mask`=8'h10 lights `dp` only while `sel`=4.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int NDIGITS = 8;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // True when nibbles idx..7 of word are all zero (the digit is a leading zero).
    function automatic logic upper_zero(input logic [31:0] word, input logic [2:0] idx);
        logic z;
        z = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            if ((i >= int'(idx)) && (word[4*i +: 4] != 4'h0)) begin
                z = 1'b0;
            end
        end
        return z;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Full hexadecimal decode table.
    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 8-digit common-anode display scanner with frame-atomic loads,
// anti-ghosting gaps and optional leading-zero blanking.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIV = 100000,
    parameter int GAP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] datain,
    input  logic        load,
    input  logic        en,
    input  logic        blank_zero,
    input  logic [7:0]  dp_mask,
    output logic [31:0] data_q,
    output logic [2:0]  sel,
    input  logic [3:0]  nibble,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        pending,
    output logic        frame_done
);

    localparam int              PW   = $clog2(DIV);
    localparam logic [PW-1:0]   LAST = PW'(DIV - 1);
    localparam logic [PW-1:0]   GAPV = PW'(GAP);

    logic [PW-1:0] pcnt_r;
    logic [2:0]    sel_r;
    logic [31:0]   data_r;
    logic [31:0]   stage_r;
    logic          pending_r;
    logic          frame_done_r;
    logic [7:0]    an_r;
    logic [6:0]    seg_r;
    logic          dp_r;

    logic          tick_s;
    logic          boundary_s;
    logic          blank_s;
    logic [6:0]    dec_s;

    seg7_decode u_decode (
        .nibble (nibble),
        .seg    (dec_s)
    );

    // Slot tick, frame boundary and blanking conditions for the current digit.
    always_comb begin
        tick_s     = en && (pcnt_r == LAST);
        boundary_s = tick_s && (sel_r == 3'd7);
        blank_s    = (pcnt_r < GAPV) || !en ||
                     (blank_zero && (sel_r != 3'd0) && upper_zero(data_r, sel_r));
    end

    // Prescaler and digit index; both freeze while scanning is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_r <= '0;
            sel_r  <= 3'd0;
        end else if (tick_s) begin
            pcnt_r <= '0;
            sel_r  <= sel_r + 3'd1;
        end else if (en) begin
            pcnt_r <= pcnt_r + PW'(1);
        end
    end

    // Staging register and pending flag; a load on the boundary re-arms pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_r   <= 32'h0000_0000;
            pending_r <= 1'b0;
        end else if (load) begin
            stage_r   <= datain;
            pending_r <= 1'b1;
        end else if (boundary_s) begin
            pending_r <= 1'b0;
        end
    end

    // Active word only changes at a frame boundary so a frame is never torn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r       <= 32'h0000_0000;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= boundary_s;
            if (boundary_s && pending_r) begin
                data_r <= stage_r;
            end
        end
    end

    // Registered active-low display drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_r  <= AN_OFF;
            seg_r <= SEG_OFF;
            dp_r  <= 1'b1;
        end else if (blank_s) begin
            an_r  <= AN_OFF;
            seg_r <= SEG_OFF;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= ~(8'h01 << sel_r);
            seg_r <= dec_s;
            dp_r  <= ~dp_mask[sel_r];
        end
    end

    assign data_q     = data_r;
    assign sel        = sel_r;
    assign an         = an_r;
    assign seg        = seg_r;
    assign dp         = dp_r;
    assign pending    = pending_r;
    assign frame_done = frame_done_r;

endmodule
